// File: rtl/bomb_pkg.sv
// Shared map geometry and cell encodings for the bomb placer and the ticker it feeds.
package bomb_pkg;

  localparam int MAP_CELLS = 100;
  localparam int CELL_W    = 2;
  localparam int MAP_W     = MAP_CELLS * CELL_W;
  localparam int COOL_W    = 3;

  localparam logic [CELL_W-1:0] CELL_NONE    = 2'd0;
  localparam logic [CELL_W-1:0] CELL_PENDING = 2'd1;
  localparam logic [CELL_W-1:0] CELL_EXPLODE = 2'd3;

  localparam logic [3:0] PLAYABLE_MIN = 4'd1;
  localparam logic [3:0] PLAYABLE_MAX = 4'd8;

  typedef logic [6:0] cellIdx_t;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_t;

  function automatic logic isPlayable(input logic [3:0] x, input logic [3:0] y);
    return (x >= PLAYABLE_MIN) && (x <= PLAYABLE_MAX) &&
           (y >= PLAYABLE_MIN) && (y <= PLAYABLE_MAX);
  endfunction

  function automatic cellIdx_t cellIndex(input logic [3:0] x, input logic [3:0] y);
    logic [7:0] idx;
    idx = 8'(x) * 8'd10 + 8'(y);
    return cellIdx_t'(idx);
  endfunction

  // Border cells are never shown to the ticker, so the merge masks them out.
  function automatic logic [MAP_CELLS-1:0] playableMask();
    logic [MAP_CELLS-1:0] mask;
    mask = '0;
    for (int x = 0; x < 10; x++) begin
      for (int y = 0; y < 10; y++) begin
        if (x >= int'(PLAYABLE_MIN) && x <= int'(PLAYABLE_MAX) &&
            y >= int'(PLAYABLE_MIN) && y <= int'(PLAYABLE_MAX)) begin
          mask[10*x+y] = 1'b1;
        end
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/bomb_placer_drop_arbiter.sv
// Per-player drop handshake: one decision per request, a registered ack/ok pulse, and a cooldown timer.
module drop_arbiter
  import bomb_pkg::*;
#(
  parameter int COOLDOWN = 1
) (
  input  logic bombClk,
  input  logic rst,
  input  logic req,
  input  logic gameOver,
  input  logic inRange,
  input  logic occupied,
  input  logic atLimit,
  output logic ack,
  output logic ok,
  output logic accept
);

  typedef enum logic {
    HS_IDLE = 1'b0,
    HS_ACK  = 1'b1
  } hsState_t;

  hsState_t          state;
  hsState_t          stateNext;
  logic [COOL_W-1:0] cooldown;
  logic [COOL_W-1:0] cooldownNext;
  logic              okNext;

  always_ff @(posedge bombClk or posedge rst) begin
    if (rst) begin
      state    <= HS_IDLE;
      cooldown <= '0;
      ok       <= 1'b0;
    end else begin
      state    <= stateNext;
      cooldown <= cooldownNext;
      ok       <= okNext;
    end
  end

  // While the ack is out no decision is taken, which gives the requester a cycle to drop req.
  always_comb begin
    stateNext    = HS_IDLE;
    accept       = 1'b0;
    okNext       = 1'b0;
    cooldownNext = cooldown;
    if (cooldown != '0) begin
      cooldownNext = cooldown - COOL_W'(1);
    end
    if (state == HS_IDLE && req) begin
      stateNext = HS_ACK;
      accept    = !gameOver && inRange && !occupied && !atLimit && (cooldown == '0);
      okNext    = accept;
    end
    if (accept) begin
      cooldownNext = COOL_W'(COOLDOWN);
    end
  end

  assign ack = (state == HS_ACK);

endmodule

// File: rtl/bomb_placer.sv
// Bomb placer: validates drop requests from players A and B and overlays accepted bombs
// onto the ticker's registered map, tracking bomb ownership so per-player counts fall on explosion.
module bomb_placer
  import bomb_pkg::*;
#(
  parameter int MAX_BOMBS = 2,
  parameter int COOLDOWN  = 1
) (
  input  logic             bombClk,
  input  logic             rst,
  input  logic [MAP_W-1:0] i_updatedBombMap,
  input  logic [1:0]       game_state,
  input  logic [3:0]       playerAx,
  input  logic [3:0]       playerAy,
  input  logic [3:0]       playerBx,
  input  logic [3:0]       playerBy,
  input  logic             dropA_req,
  input  logic             dropB_req,
  output logic             dropA_ack,
  output logic             dropB_ack,
  output logic             dropA_ok,
  output logic             dropB_ok,
  output logic [MAP_W-1:0] o_curBombMap,
  output logic [1:0]       o_countA,
  output logic [1:0]       o_countB
);

  localparam logic [MAP_CELLS-1:0] PLAY_MASK = playableMask();

  logic [MAP_CELLS-1:0] pending;
  logic [MAP_CELLS-1:0] pendingNext;
  logic [MAP_CELLS-1:0] bombValid;
  logic [MAP_CELLS-1:0] validNext;
  logic [MAP_CELLS-1:0] bombOwner;
  logic [MAP_CELLS-1:0] ownerNext;
  logic [MAP_W-1:0]     mergedMap;

  logic     gameOver;
  logic     inRangeA, inRangeB;
  cellIdx_t idxA, idxB;
  logic     occupiedA, occupiedB;
  logic     atLimitA, atLimitB;
  logic     acceptA, acceptB;
  logic [6:0] retireA, retireB;
  logic [1:0] countANext, countBNext;

  function automatic logic [1:0] nextCount(input logic [1:0] cur, input logic inc,
                                           input logic [6:0] dec);
    logic [7:0] sum;
    sum = {6'd0, cur} + {7'd0, inc};
    if (sum < {1'b0, dec}) begin
      return 2'd0;
    end
    return 2'(sum - {1'b0, dec});
  endfunction

  // A freshly accepted bomb shows as 1 only until the ticker has written its own value there.
  always_comb begin
    mergedMap = '0;
    for (int i = 0; i < MAP_CELLS; i++) begin
      if (PLAY_MASK[i]) begin
        if (pending[i] && i_updatedBombMap[CELL_W*i +: CELL_W] == CELL_NONE) begin
          mergedMap[CELL_W*i +: CELL_W] = CELL_PENDING;
        end else begin
          mergedMap[CELL_W*i +: CELL_W] = i_updatedBombMap[CELL_W*i +: CELL_W];
        end
      end
    end
  end

  assign o_curBombMap = mergedMap;

  assign gameOver  = (game_state != 2'd0);
  assign inRangeA  = isPlayable(playerAx, playerAy);
  assign inRangeB  = isPlayable(playerBx, playerBy);
  assign idxA      = inRangeA ? cellIndex(playerAx, playerAy) : '0;
  assign idxB      = inRangeB ? cellIndex(playerBx, playerBy) : '0;
  assign atLimitA  = (o_countA == 2'(MAX_BOMBS));
  assign atLimitB  = (o_countB == 2'(MAX_BOMBS));
  assign occupiedA = (mergedMap[CELL_W*idxA +: CELL_W] != CELL_NONE);
  // A wins a same-cell tie: B sees A's accept as if the bomb were already on the map.
  assign occupiedB = (mergedMap[CELL_W*idxB +: CELL_W] != CELL_NONE) ||
                     (acceptA && (idxA == idxB));

  drop_arbiter #(.COOLDOWN(COOLDOWN)) arbA (
    .bombClk  (bombClk),
    .rst      (rst),
    .req      (dropA_req),
    .gameOver (gameOver),
    .inRange  (inRangeA),
    .occupied (occupiedA),
    .atLimit  (atLimitA),
    .ack      (dropA_ack),
    .ok       (dropA_ok),
    .accept   (acceptA)
  );

  drop_arbiter #(.COOLDOWN(COOLDOWN)) arbB (
    .bombClk  (bombClk),
    .rst      (rst),
    .req      (dropB_req),
    .gameOver (gameOver),
    .inRange  (inRangeB),
    .occupied (occupiedB),
    .atLimit  (atLimitB),
    .ack      (dropB_ack),
    .ok       (dropB_ok),
    .accept   (acceptB)
  );

  always_comb begin
    pendingNext = '0;
    validNext   = bombValid;
    ownerNext   = bombOwner;
    retireA     = '0;
    retireB     = '0;
    for (int i = 0; i < MAP_CELLS; i++) begin
      if (bombValid[i] && mergedMap[CELL_W*i +: CELL_W] == CELL_EXPLODE) begin
        validNext[i] = 1'b0;
        if (bombOwner[i] == OWNER_B) begin
          retireB = retireB + 7'd1;
        end else begin
          retireA = retireA + 7'd1;
        end
      end
    end
    if (acceptA) begin
      pendingNext[idxA] = 1'b1;
      validNext[idxA]   = 1'b1;
      ownerNext[idxA]   = OWNER_A;
    end
    if (acceptB) begin
      pendingNext[idxB] = 1'b1;
      validNext[idxB]   = 1'b1;
      ownerNext[idxB]   = OWNER_B;
    end
  end

  assign countANext = nextCount(o_countA, acceptA, retireA);
  assign countBNext = nextCount(o_countB, acceptB, retireB);

  always_ff @(posedge bombClk or posedge rst) begin
    if (rst) begin
      pending   <= '0;
      bombValid <= '0;
      bombOwner <= '0;
      o_countA  <= '0;
      o_countB  <= '0;
    end else begin
      pending   <= pendingNext;
      bombValid <= validNext;
      bombOwner <= ownerNext;
      o_countA  <= countANext;
      o_countB  <= countBNext;
    end
  end

endmodule
